full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- 1-bit full adder: Sum = A xor B xor Cin, Carry = majority(A,B,Cin).
- Sum/Carry are purely combinational and independent of clock and reset.
- Also provides a one-cycle registered copy of the result and a saturating count of carry-out events, for pipelined consumers and self-check.
- Leaf arithmetic cell, instantiated per bit in ripple adders and used standalone in bring-up benches.

Parameters:
- CNT_W, default 8, width of the carry-event counter Carry_cnt (legal range 1..32).

Ports:
- clock  input  1  single system clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- A  input  1  addend bit.
- B  input  1  addend bit.
- Cin  input  1  carry-in bit.
- Sum  output  1  combinational sum, A^B^Cin.
- Carry  output  1  combinational carry-out, (A&B)|(A&Cin)|(B&Cin).
- Sum_q  output  1  Sum registered one clock later.
- Carry_q  output  1  Carry registered one clock later.
- Carry_cnt  output  CNT_W  saturating count of clock edges on which Carry was 1.

Behaviour:
- Combinational path:
  - Sum and Carry follow A/B/Cin with zero clock latency; no latches, no clock or reset gating.
  - Valid at any time, including during reset.
  - Truth table (ABCin -> Sum Carry): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
  - Arithmetic identity: {Carry,Sum} = A+B+Cin, a 2-bit unsigned value in 0..3.
- Registered path:
  - On a rising edge with reset=1: Sum_q=0, Carry_q=0, Carry_cnt=0.
  - On a rising edge with reset=0: Sum_q<=Sum, Carry_q<=Carry. Latency is exactly 1 cycle.
  - Inputs that change and return between edges are not captured (glitch-free sampling only).
- Carry counter:
  - On a rising edge with reset=0 and Carry=1: Carry_cnt<=Carry_cnt+1, unless Carry_cnt = 2^CNT_W-1, in which case it holds (saturates, no wrap).
  - Carry=0 -> Carry_cnt holds.
- Reset:
  - Reset has priority over counting.
  - Reset asserted mid-operation clears Sum_q, Carry_q and Carry_cnt at the next edge; Sum/Carry are unaffected.
  - After reset deasserts, the first edge captures the current inputs.
- Power-up: registered outputs are undefined until the first reset edge; the combinational outputs are defined immediately.
- Inputs X/Z: no requirement beyond standard propagation.

Test Plan:
- Exhaustive combinational: drive all 8 ABCin combos, check each between clock edges -> matches the truth table, e.g. 101 -> Sum=0 Carry=1; 111 -> Sum=1 Carry=1.
- Toggle sweep: start A=B=Cin=0, toggle A every 10 ns, B every 10 ns, Cin every 5 ns (10 ns clock), 8x8x4 nested -> Sum/Carry always equal (A+B+Cin)[0]/[1] at every display point.
- Registered latency: reset for 2 cycles, then apply 011 before edge N -> Sum_q=0, Carry_q=1 after edge N, not before; Sum=0 Carry=1 immediately.
- Counter: reset, hold 110 for 5 edges, then 000 for 3 edges -> Carry_cnt=5 and holds at 5.
- Saturation: CNT_W=2, hold 111 for 6 edges -> Carry_cnt sequence 1,2,3,3,3,3.
- Reset mid-run: Carry_cnt=4, assert reset for one edge with inputs 111 -> Carry_cnt=0, Sum_q=0, Carry_q=0; Sum=1 Carry=1 throughout; next edge gives Carry_cnt=1.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder with registered result copy and saturating carry-event counter
//   clock     : system clock, registers update on rising edge
//   reset     : synchronous active-high reset
//   A, B, Cin : addend bits and carry-in
//   Sum, Carry: combinational result, valid at all times
//   Sum_q, Carry_q : result registered one cycle later
//   Carry_cnt : saturating count of edges where Carry was 1
module full_adder #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    output logic             Sum,
    output logic             Carry,
    output logic             Sum_q,
    output logic             Carry_q,
    output logic [CNT_W-1:0] Carry_cnt
);
    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (A & Cin) | (B & Cin);
    always_ff @(posedge clock) begin
        if (reset) begin
            Sum_q     <= 1'b0;
            Carry_q   <= 1'b0;
            Carry_cnt <= '0;
        end else begin
            Sum_q   <= Sum;
            Carry_q <= Carry;
            // all-ones is the saturation point; hold instead of wrapping
            if (Carry && Carry_cnt != '1)
                Carry_cnt <= Carry_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed self-check of full_adder against an arithmetic model
module tb_full_adder;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       A = 1'b0, B = 1'b0, Cin = 1'b0;
    logic       sum8, carry8, sum_q8, carry_q8;
    logic       sum2, carry2, sum_q2, carry_q2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    int         checks = 0;
    int         errors = 0;
    int         m_sq, m_cq, m_c8, m_c2;
    int         sat_seq [6] = '{1, 2, 3, 3, 3, 3};

    always #5 clock = ~clock;

    full_adder #(.CNT_W(8)) dut8 (
        .clock(clock), .reset(reset), .A(A), .B(B), .Cin(Cin),
        .Sum(sum8), .Carry(carry8), .Sum_q(sum_q8), .Carry_q(carry_q8), .Carry_cnt(cnt8)
    );

    full_adder #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .A(A), .B(B), .Cin(Cin),
        .Sum(sum2), .Carry(carry2), .Sum_q(sum_q2), .Carry_q(carry_q2), .Carry_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string when);
        check({"sum_q8 ", when}, 32'(sum_q8), m_sq);
        check({"carry_q8 ", when}, 32'(carry_q8), m_cq);
        check({"cnt8 ", when}, 32'(cnt8), m_c8);
        check({"sum_q2 ", when}, 32'(sum_q2), m_sq);
        check({"carry_q2 ", when}, 32'(carry_q2), m_cq);
        check({"cnt2 ", when}, 32'(cnt2), m_c2);
    endtask

    // one clock cycle: drive inputs on the falling edge, optionally glitch them first
    task automatic step(input logic a, input logic b, input logic c, input logic r, input bit glitch);
        int s;
        s = int'(a) + int'(b) + int'(c);
        @(negedge clock);
        if (glitch) begin
            A = ~a; B = ~b; Cin = ~c;
            #1;
        end
        A = a; B = b; Cin = c; reset = r;
        #1;
        check("sum8", 32'(sum8), s % 2);
        check("carry8", 32'(carry8), s / 2);
        check("sum2", 32'(sum2), s % 2);
        check("carry2", 32'(carry2), s / 2);
        check_regs("pre-edge");
        @(posedge clock);
        if (r) begin
            m_sq = 0; m_cq = 0; m_c8 = 0; m_c2 = 0;
        end else begin
            m_sq = s % 2;
            m_cq = s / 2;
            if (s >= 2) begin
                m_c8 = (m_c8 == 255) ? 255 : m_c8 + 1;
                m_c2 = (m_c2 == 3) ? 3 : m_c2 + 1;
            end
        end
        #1;
        check_regs("post-edge");
    endtask

    initial begin
        m_sq = 0; m_cq = 0; m_c8 = 0; m_c2 = 0;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("reset cnt8", 32'(cnt8), 0);
        step(0, 1, 1, 0, 0);
        check("latency carry_q", 32'(carry_q8), 1);
        check("latency sum_q", 32'(sum_q8), 0);
        for (int i = 0; i < 8; i++)
            step(i[2], i[1], i[0], 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0);
        check("cnt8 holds 5", 32'(cnt8), 5);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 0, 0);
            check("cnt2 sat seq", 32'(cnt2), sat_seq[i]);
        end
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 0);
        check("cnt8 before midreset", 32'(cnt8), 4);
        step(1, 1, 1, 1, 0);
        check("midreset cnt8", 32'(cnt8), 0);
        check("midreset carry", 32'(carry8), 1);
        step(1, 1, 1, 0, 0);
        check("after midreset cnt8", 32'(cnt8), 1);
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 24) == 0, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
